sram_line_controller: RTL and testbench

- Responder side of the cache-to-SRAM interface. Accepts a line read (sramRdEn) or word write (sramWrEn) from the cache controller and sequences 16-bit accesses on an external asynchronous SRAM (256K x 16).
- Returns a 64-bit line and a one-cycle sramReady pulse.
- Sits between the cache controller and the SRAM pins in the memory stage.

---
 rtl/sram_line_controller.sv | 210 +++++++++++++++++++++
 tb/tb_sram_line_controller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_line_controller.sv
// -----------------------------------------------------------------------------
// sram_line_controller
//
// Responder between the cache controller and an external asynchronous
// 256K x 16 SRAM. A line read fetches four consecutive halfwords into a
// 64-bit line; a word write stores two halfwords. Each 16-bit beat lasts
// WAIT_CYCLES+1 clock cycles. sramReady pulses for one cycle when the
// transaction completes.
//
// Handshake: the requester raises sramRdEn or sramWrEn and holds it, together
// with address and writeData, until it sees sramReady. Requests are only
// sampled in IDLE; a request still high in the IDLE cycle after DONE starts a
// new transaction. Write wins if both requests are high.
//
// Optional feature (macro SRAM_LINE_BUFFER_EN): a one-entry line buffer (tag
// address[18:3] plus valid bit). A read hitting the buffer goes straight to
// DONE. A write hitting the buffer also patches the buffered line.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   sramRdEn      line-read request
//   sramWrEn      word-write request
//   address       byte address, bits [18:1] used
//   writeData     write word
//   sramReadData  fetched line, [15:0] from the lowest halfword address
//   sramReady     one-cycle completion pulse
//   SRAM_ADDR     halfword address to the SRAM
//   SRAM_DQ_OUT   write data to the pad
//   SRAM_DQ_IN    read data from the pad
//   SRAM_DQ_OE    pad output enable
//   SRAM_*_N      SRAM strobes, active-low
//   dbg_state     current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 DONE)
// -----------------------------------------------------------------------------
module sram_line_controller #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sramRdEn,
    input  logic        sramWrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [63:0] sramReadData,
    output logic        sramReady,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CYC = 3'(WAIT_CYCLES);

    state_t     state;
    state_t     next_state;
    logic [1:0] beat;
    logic [2:0] cyc;
    logic       beat_end;
    logic       buf_hit;
    logic       addr_unused;

    assign beat_end    = (cyc == LAST_CYC);
    assign dbg_state   = state;
    assign addr_unused = ^{address[31:19], address[1:0]};

`ifdef SRAM_LINE_BUFFER_EN
    logic [15:0] buf_tag;
    logic        buf_valid;

    assign buf_hit = buf_valid && (buf_tag == address[18:3]);
`else
    assign buf_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sramWrEn) begin
                    next_state = WRITE;
                end else if (sramRdEn) begin
                    next_state = buf_hit ? DONE : READ;
                end
            end
            READ: begin
                if (beat_end && beat == 2'd3) begin
                    next_state = DONE;
                end
            end
            WRITE: begin
                if (beat_end && beat[0]) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Beat / cycle counters; cleared whenever no transfer is in progress so
    // every READ or WRITE starts at beat 0, cycle 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= 2'd0;
            cyc  <= 3'd0;
        end else if (state == READ || state == WRITE) begin
            if (beat_end) begin
                cyc  <= 3'd0;
                beat <= beat + 2'd1;
            end else begin
                cyc <= cyc + 3'd1;
            end
        end else begin
            beat <= 2'd0;
            cyc  <= 3'd0;
        end
    end

    // Line register (and line buffer tag when enabled). Data is captured on
    // the last cycle of each read beat, giving the SRAM the full beat to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sramReadData <= 64'd0;
`ifdef SRAM_LINE_BUFFER_EN
            buf_tag   <= 16'd0;
            buf_valid <= 1'b0;
`endif
        end else begin
            if (state == READ && beat_end) begin
                sramReadData[{beat, 4'b0000} +: 16] <= SRAM_DQ_IN;
            end
`ifdef SRAM_LINE_BUFFER_EN
            if (state == READ && beat_end && beat == 2'd3) begin
                buf_tag   <= address[18:3];
                buf_valid <= 1'b1;
            end
            // Keep the buffered line coherent with the word just written.
            if (state == WRITE && beat_end && beat[0] && buf_hit) begin
                sramReadData[{address[2], 5'b00000} +: 32] <= writeData;
            end
`endif
        end
    end

    // Output decode
    always_comb begin
        sramReady   = 1'b0;
        SRAM_ADDR   = 18'd0;
        SRAM_DQ_OUT = 16'd0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_CE_N   = 1'b1;
        SRAM_UB_N   = 1'b1;
        SRAM_LB_N   = 1'b1;
        case (state)
            READ: begin
                SRAM_ADDR = {address[18:3], beat};
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            WRITE: begin
                SRAM_ADDR   = {address[18:2], beat[0]};
                SRAM_DQ_OUT = beat[0] ? writeData[31:16] : writeData[15:0];
                SRAM_DQ_OE  = 1'b1;
                SRAM_CE_N   = 1'b0;
                SRAM_UB_N   = 1'b0;
                SRAM_LB_N   = 1'b0;
                // WE_N rises on the final cycle of the beat so address and
                // data are held stable across the write-enable release.
                SRAM_WE_N   = beat_end;
            end
            DONE: begin
                sramReady = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sram_line_controller.sv
`timescale 1ns/1ps
module tb_sram_line_controller;

    localparam int W      = 1;
    localparam int RD_LAT = 4 * (W + 1) + 1;
    localparam int WR_LAT = 2 * (W + 1) + 1;
`ifdef SRAM_LINE_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif
    localparam int HIT = BUF ? 1 : RD_LAT;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst_n;
    logic        sramRdEn;
    logic        sramWrEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [63:0] sramReadData;
    logic        sramReady;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_DQ_OE;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
    logic [1:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_line_controller #(.WAIT_CYCLES(W)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .sramRdEn     (sramRdEn),
        .sramWrEn     (sramWrEn),
        .address      (address),
        .writeData    (writeData),
        .sramReadData (sramReadData),
        .sramReady    (sramReady),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_DQ_OUT  (SRAM_DQ_OUT),
        .SRAM_DQ_IN   (SRAM_DQ_IN),
        .SRAM_DQ_OE   (SRAM_DQ_OE),
        .SRAM_WE_N    (SRAM_WE_N),
        .SRAM_OE_N    (SRAM_OE_N),
        .SRAM_CE_N    (SRAM_CE_N),
        .SRAM_UB_N    (SRAM_UB_N),
        .SRAM_LB_N    (SRAM_LB_N),
        .dbg_state    (dbg_state)
    );

    // ---------------- asynchronous SRAM model ----------------
    bit   [15:0] sram [0:262143];
    logic        pre_we;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;

    assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR] : 16'h0000;

    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] <= SRAM_DQ_OUT;
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];
    bit          buf_valid;
    logic [15:0] buf_tag;
    logic [63:0] cur_line;

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic model_read(input logic [31:0] a, output int lat, output logic [63:0] line);
        int base;
        base = int'({a[18:3], 2'b00});
        if (BUF && buf_valid && buf_tag == a[18:3]) begin
            lat  = 1;
            line = cur_line;
        end else begin
            lat      = RD_LAT;
            line     = {ref_rd(base + 3), ref_rd(base + 2), ref_rd(base + 1), ref_rd(base)};
            cur_line = line;
            if (BUF) begin
                buf_valid = 1'b1;
                buf_tag   = a[18:3];
            end
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               output int lat, output logic [63:0] line);
        ref_mem[int'({a[18:2], 1'b0})] = d[15:0];
        ref_mem[int'({a[18:2], 1'b1})] = d[31:16];
        if (BUF && buf_valid && buf_tag == a[18:3]) begin
            if (a[2]) cur_line[63:32] = d;
            else      cur_line[31:0]  = d;
        end
        lat  = WR_LAT;
        line = cur_line;
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [17:0] exp_trace[$];
    logic [17:0] got_trace[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // kind: 0 read, 1 write, 2 both requests high (write expected)
    task automatic run_txn(input int kind, input logic [31:0] a, input logic [31:0] d,
                           input int exp_lat, input logic [63:0] exp_line, input string tag);
        int cyc;
        int oe_cnt;
        int we_cnt;
        bit seen;
        int n;
        exp_trace.delete();
        got_trace.delete();
        if (kind != 0) begin
            exp_trace.push_back({a[18:2], 1'b0});
            exp_trace.push_back({a[18:2], 1'b1});
        end else if (exp_lat != 1) begin
            for (int i = 0; i < 4; i++) exp_trace.push_back({a[18:3], 2'(i)});
        end
        exp_q.push_back(exp_line);
        @(negedge clk);
        address   = a;
        writeData = d;
        sramRdEn  = (kind != 1);
        sramWrEn  = (kind != 0);
        cyc = 0; oe_cnt = 0; we_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!SRAM_OE_N) oe_cnt++;
            if (!SRAM_WE_N) we_cnt++;
            if (!SRAM_CE_N && (got_trace.size() == 0 || got_trace[$] != SRAM_ADDR))
                got_trace.push_back(SRAM_ADDR);
            if (sramReady) seen = 1'b1;
        end
        sramRdEn = 1'b0;
        sramWrEn = 1'b0;
        check({tag, "_ready_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_line"}, sramReadData, exp_q.pop_front());
        check({tag, "_oe_cycles"}, 64'(oe_cnt),
              64'((kind == 0 && exp_lat != 1) ? 4 * (W + 1) : 0));
        check({tag, "_we_cycles"}, 64'(we_cnt), 64'((kind != 0) ? 2 * W : 0));
        check({tag, "_trace_len"}, 64'(got_trace.size()), 64'(exp_trace.size()));
        n = (got_trace.size() < exp_trace.size()) ? got_trace.size() : exp_trace.size();
        for (int i = 0; i < n; i++) check({tag, "_addr"}, 64'(got_trace[i]), 64'(exp_trace[i]));
        @(negedge clk);
        check({tag, "_ready_one_cycle"}, 64'(sramReady), 64'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [63:0] line;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [63:0] line;
        int          gap;
        int          oe2;
        bit          seen;
        logic [17:0] pa  [8];
        logic [15:0] pd  [8];

        vecs[0]  = '{0, 32'h0000_0200, 32'h0, RD_LAT, 64'h4444_3333_2222_1111};
        vecs[1]  = '{1, 32'h0000_0206, 32'hDEAD_BEEF, WR_LAT,
                     BUF ? 64'hDEAD_BEEF_2222_1111 : 64'h4444_3333_2222_1111};
        vecs[2]  = '{0, 32'h0000_0200, 32'h0, HIT, 64'hDEAD_BEEF_2222_1111};
        vecs[3]  = '{1, 32'h0000_0204, 32'hCAFE_F00D, WR_LAT,
                     BUF ? 64'hCAFE_F00D_2222_1111 : 64'hDEAD_BEEF_2222_1111};
        vecs[4]  = '{0, 32'h0000_0200, 32'h0, HIT, 64'hCAFE_F00D_2222_1111};
        vecs[5]  = '{0, 32'h0008_0200, 32'h0, HIT, 64'hCAFE_F00D_2222_1111};
        vecs[6]  = '{0, 32'h0000_0208, 32'h0, RD_LAT, 64'h0};
        vecs[7]  = '{0, 32'h0007_FFF8, 32'h0, RD_LAT, 64'hD3D3_C2C2_B1B1_A0A0};
        vecs[8]  = '{1, 32'h0007_FFFC, 32'h1234_5678, WR_LAT,
                     BUF ? 64'h1234_5678_B1B1_A0A0 : 64'hD3D3_C2C2_B1B1_A0A0};
        vecs[9]  = '{0, 32'hFFF7_FFF8, 32'h0, HIT, 64'h1234_5678_B1B1_A0A0};
        vecs[10] = '{2, 32'h0000_0300, 32'h55AA_33CC, WR_LAT, 64'h1234_5678_B1B1_A0A0};
        vecs[11] = '{0, 32'h0000_0300, 32'h0, RD_LAT, 64'h0000_0000_55AA_33CC};

        pa[0] = 18'h00100; pd[0] = 16'h1111;
        pa[1] = 18'h00101; pd[1] = 16'h2222;
        pa[2] = 18'h00102; pd[2] = 16'h3333;
        pa[3] = 18'h00103; pd[3] = 16'h4444;
        pa[4] = 18'h3FFFC; pd[4] = 16'hA0A0;
        pa[5] = 18'h3FFFD; pd[5] = 16'hB1B1;
        pa[6] = 18'h3FFFE; pd[6] = 16'hC2C2;
        pa[7] = 18'h3FFFF; pd[7] = 16'hD3D3;

        rst_n = 1'b0; sramRdEn = 1'b0; sramWrEn = 1'b0;
        address = 32'h0; writeData = 32'h0;
        pre_we = 1'b0; pre_addr = 18'h0; pre_data = 16'h0;
        buf_valid = 1'b0; buf_tag = 16'h0; cur_line = 64'h0;

        // preload SRAM and the model while reset is held
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = pa[i]; pre_data = pd[i];
            ref_mem[int'(pa[i])] = pd[i];
        end
        @(negedge clk);
        pre_we = 1'b0;

        // reset state
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_ready", 64'(sramReady), 64'd0);
        check("rst_line", sramReadData, 64'h0);
        check("rst_addr", 64'(SRAM_ADDR), 64'h0);
        check("rst_dq_out", 64'(SRAM_DQ_OUT), 64'h0);
        check("rst_dq_oe", 64'(SRAM_DQ_OE), 64'h0);
        check("rst_strobes", 64'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 64'h1F);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven directed vectors; model kept in step
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].kind == 0) model_read(vecs[i].addr, lat, line);
            else                   model_write(vecs[i].addr, vecs[i].wdata, lat, line);
            run_txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].line,
                    $sformatf("vec%0d", i));
        end

        // reset in cycle 3 of a read
        @(negedge clk);
        address = 32'h0007_FFF8; sramRdEn = 1'b1;
        repeat (3) @(negedge clk);
        check("midrd_in_read", 64'(SRAM_OE_N), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrd_strobes", 64'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 64'h1F);
        check("midrd_ready", 64'(sramReady), 64'd0);
        check("midrd_line", sramReadData, 64'h0);
        check("midrd_state", 64'(dbg_state), 64'd0);
        sramRdEn = 1'b0;
        buf_valid = 1'b0; cur_line = 64'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (sramReady) seen = 1'b1;
        end
        check("midrd_no_ready", 64'(seen), 64'd0);
        model_read(32'h0007_FFF8, lat, line);
        run_txn(0, 32'h0007_FFF8, 32'h0, lat, line, "after_rst");

        // back-to-back reads with sramRdEn held through sramReady
        model_read(32'h0000_0200, lat, line);
        exp_q.push_back(line);
        @(negedge clk);
        address = 32'h0000_0200; sramRdEn = 1'b1;
        gap = 0; seen = 1'b0;
        while (!seen && gap < 200) begin
            @(negedge clk); gap++;
            if (sramReady) seen = 1'b1;
        end
        check("b2b_first_lat", 64'(gap), 64'(lat));
        check("b2b_first_line", sramReadData, exp_q.pop_front());
        model_read(32'h0000_0200, lat, line);
        exp_q.push_back(line);
        exp_trace.delete(); got_trace.delete();
        gap = 0; oe2 = 0; seen = 1'b0;
        while (!seen && gap < 200) begin
            @(negedge clk); gap++;
            if (!SRAM_OE_N) oe2++;
            if (!SRAM_CE_N && got_trace.size() == 0) got_trace.push_back(SRAM_ADDR);
            if (sramReady) seen = 1'b1;
        end
        sramRdEn = 1'b0;
        check("b2b_gap", 64'(gap), 64'(lat + 1));
        check("b2b_second_line", sramReadData, exp_q.pop_front());
        check("b2b_second_oe", 64'(oe2), 64'((lat == 1) ? 0 : 4 * (W + 1)));
        if (got_trace.size() != 0) check("b2b_restart_addr", 64'(got_trace[0]), 64'h00100);
        @(negedge clk);

        // randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 2);
            a = ($urandom & 32'hFFF8_0000) | 32'h0000_0200 |
                (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 1);
            d = $urandom;
            if (kind == 0) model_read(a, lat, line);
            else           model_write(a, d, lat, line);
            run_txn(kind, a, d, lat, line, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
